digit_scanner: RTL and testbench

DIGIT_SCANNER -- requirements
Module: digit_scanner

---
 rtl/digit_scanner_pkg.sv | 16 +
 rtl/digit_scanner_tick.sv | 24 ++
 rtl/digit_scanner.sv | 90 +++++++++
 tb/tb_digit_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/digit_scanner_pkg.sv
// Shared constants and helpers for the multiplexed hex digit scanner.
package digit_scanner_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;

    function automatic logic [NUM_DIGITS-1:0] anode_sel(
        input logic [IDX_W-1:0] idx
    );
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/digit_scanner_tick.sv
// Slot prescaler: free-running 0..CLK_DIV-1 counter with a wrap strobe.
module tick_gen #(
    parameter  int CLK_DIV = 100000,
    localparam int CW      = $clog2(CLK_DIV)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] count,
    output logic          tick
);

    assign tick = (count == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/digit_scanner.sv
// Four-digit multiplexed hex display driver with frame-aligned,
// tear-free value updates and optional leading-zero blanking.
module digit_scanner
    import digit_scanner_pkg::*;
#(
    parameter int CLK_DIV     = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] value,
    input  logic                          blank_lz,
    output logic [DIGIT_W-1:0]            digit,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          pending
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int VW = NUM_DIGITS * DIGIT_W;
    localparam logic [CW-1:0] DEAD = CW'(DEAD_CYCLES);

    logic [CW-1:0]         count;
    logic                  tick;
    logic [IDX_W-1:0]      idx;
    logic [VW-1:0]         disp;
    logic [VW-1:0]         shadow;
    logic                  frame;
    logic [NUM_DIGITS-1:0] blank;
    logic                  upper_zero;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .count (count),
        .tick  (tick)
    );

    assign frame = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            disp    <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (tick) begin
                idx <= idx + IDX_W'(1);
            end
            // A load on the boundary itself bypasses the shadow: newest wins.
            if (frame) begin
                if (load) begin
                    disp   <= value;
                    shadow <= value;
                end else if (pending) begin
                    disp <= shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end
        end
    end

    // Digit k blanks when it and every digit above it are zero.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (disp[k*DIGIT_W +: DIGIT_W] == '0);
            blank[k]   = blank_lz && upper_zero;
        end
    end

    always_comb begin
        digit = disp[idx*DIGIT_W +: DIGIT_W];
        an    = anode_sel(idx);
        if (reset) begin
            digit = '0;
            an    = ANODES_OFF;
        end else if (count < DEAD || blank[idx]) begin
            an = ANODES_OFF;
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner with CLK_DIV=8, DEAD_CYCLES=2.
module tb_digit_scanner;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        pending;

    int          vectors;
    int          miscompares;
    int          t;
    int          bad;
    logic [15:0] watch_mask;

    digit_scanner #(
        .CLK_DIV     (8),
        .DEAD_CYCLES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .digit    (digit),
        .an       (an),
        .pending  (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d: got %h, expected %h", tag, t, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        t++;
        #1;
        if (an != 4'hf && watch_mask[digit]) bad++;
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    task automatic slot(input string tag, input int target,
                        input logic [3:0] exp_an, input logic [3:0] exp_d);
        run_to(target);
        check({tag, ".an"}, 32'(an), 32'(exp_an));
        check({tag, ".digit"}, 32'(digit), 32'(exp_d));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        t           = 0;
        bad         = 0;
        watch_mask  = '0;
        reset       = 1'b1;
        load        = 1'b0;
        value       = '0;
        blank_lz    = 1'b0;

        step();
        step();
        check("rst.an", 32'(an), 'b1111);
        check("rst.digit", 32'(digit), 'h0);
        check("rst.pending", 32'(pending), 0);

        // t counts edges after the last reset edge; frames end at t=32k
        reset = 1'b0;
        t     = 0;
        check("rel.an", 32'(an), 'b1111);

        load  = 1'b1;
        value = 16'h1234;
        step();
        load  = 1'b0;
        check("ld1.pending", 32'(pending), 1);
        check("ld1.digit", 32'(digit), 'h0);
        run_to(31);
        check("ld1.hold", 32'(pending), 1);
        step();
        check("b32.pending", 32'(pending), 0);
        check("b32.an", 32'(an), 'b1111);
        slot("s0", 34, 4'b1110, 4'h4);
        slot("s1dead", 41, 4'b1111, 4'h3);
        slot("s1", 42, 4'b1101, 4'h3);
        slot("s2", 50, 4'b1011, 4'h2);
        slot("s3", 58, 4'b0111, 4'h1);

        // two loads in one frame: only the later is ever shown
        watch_mask = 16'h3c00;
        bad        = 0;
        run_to(66);
        load  = 1'b1;
        value = 16'habcd;
        step();
        load = 1'b0;
        run_to(69);
        load  = 1'b1;
        value = 16'h5678;
        step();
        load = 1'b0;
        check("ld2.pending", 32'(pending), 1);
        slot("old3", 90, 4'b0111, 4'h1);
        run_to(96);
        check("b96.pending", 32'(pending), 0);
        slot("n0", 98, 4'b1110, 4'h8);
        slot("n1", 106, 4'b1101, 4'h7);
        slot("n2", 114, 4'b1011, 4'h6);
        slot("n3", 122, 4'b0111, 4'h5);
        check("abcd.never", 32'(bad), 0);

        // load on the boundary cycle overrides the pending shadow
        watch_mask = 16'h0002;
        bad        = 0;
        run_to(99);
        load  = 1'b1;
        value = 16'h1111;
        step();
        load = 1'b0;
        check("ld3.pending", 32'(pending), 1);
        run_to(127);
        load  = 1'b1;
        value = 16'h00f0;
        step();
        load = 1'b0;
        check("b128.pending", 32'(pending), 0);
        slot("f0", 130, 4'b1110, 4'h0);
        slot("f1", 138, 4'b1101, 4'hf);
        slot("f2", 146, 4'b1011, 4'h0);
        slot("f3", 154, 4'b0111, 4'h0);
        check("1111.never", 32'(bad), 0);

        // leading-zero blanking
        watch_mask = '0;
        run_to(155);
        blank_lz = 1'b1;
        slot("z0", 162, 4'b1110, 4'h0);
        slot("z1", 170, 4'b1101, 4'hf);
        slot("z2", 178, 4'b1111, 4'h0);
        load  = 1'b1;
        value = 16'h0000;
        step();
        load = 1'b0;
        run_to(186);
        check("z3.an", 32'(an), 'b1111);
        slot("zz0", 194, 4'b1110, 4'h0);
        slot("zz1", 202, 4'b1111, 4'h0);
        slot("zz2", 210, 4'b1111, 4'h0);
        run_to(220);
        check("zz3.an", 32'(an), 'b1111);
        blank_lz = 1'b0;
        step();
        check("lz.off.an", 32'(an), 'b0111);

        // reset mid-slot with a pending value, plus a load during reset
        run_to(224);
        load  = 1'b1;
        value = 16'h4321;
        step();
        load = 1'b0;
        check("ld4.pending", 32'(pending), 1);
        run_to(227);
        reset = 1'b1;
        load  = 1'b1;
        value = 16'h9999;
        step();
        check("mrst.an", 32'(an), 'b1111);
        check("mrst.digit", 32'(digit), 'h0);
        check("mrst.pending", 32'(pending), 0);
        reset = 1'b0;
        load  = 1'b0;
        t     = 0;
        step();
        check("post.pending", 32'(pending), 0);
        slot("t7", 7, 4'b1110, 4'h0);
        slot("t8", 8, 4'b1111, 4'h0);
        slot("t9", 9, 4'b1111, 4'h0);
        slot("t10", 10, 4'b1101, 4'h0);
        slot("t34", 34, 4'b1110, 4'h0);
        slot("t42", 42, 4'b1101, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
